// File: rtl/sdram_ctrl_arbiter_pkg.sv
// sdram_ctrl_arbiter_pkg
//   Shared types and width helpers for the SDRAM request-port arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT_RD)
//   req_idx_w() : index width for a requester count (at least 1 bit)
//   cnt_w()     : counter width able to hold values 0 .. n-1 (at least 1 bit)
package sdram_ctrl_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_ctrl_arbiter_rr_picker.sv
// sdram_ctrl_arbiter_rr_picker
//   Combinational round-robin picker. Returns the first set bit of req_i
//   searching last_i+1, last_i+2, ... wrapping around to last_i itself.
//   Ports:
//     req_i   [N_REQ]  pending request vector
//     last_i  [IDX_W]  index of the requester served most recently
//     idx_o   [IDX_W]  index of the winner (0 when nothing pending)
//     any_o   1        at least one request pending
module sdram_ctrl_arbiter_rr_picker
  import sdram_ctrl_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int c;

  // Walk the offsets from farthest to nearest so the nearest pending
  // requester after last_i is the one that sticks.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = int'(last_i) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (req_i[c[IDX_W-1:0]]) begin
        idx_o = IDX_W'(c);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_ctrl_arbiter.sv
// sdram_ctrl_arbiter
//   Shares one SDRAM controller request port among N_REQ requesters with
//   round-robin arbitration and a single transaction in flight. A grant is
//   held until the write is accepted or the read data comes back.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; s_* driven 0; pick next pending requester
//   ISSUE   | granted requester's request forwarded to the controller
//   WAIT_RD | read accepted, waiting for s_valid_i (no new grant)
//
//   Optional build macro SDRAM_ARB_TIMEOUT_EN: adds a read-wait watchdog
//   that aborts WAIT_RD with an error pulse after TIMEOUT cycles.
//
//   Ports:
//     clk_i, rst_n_i       clock, synchronous active-low reset
//     m_wr_i/m_rd_i        per-requester write byte enables / read request
//     m_addr_i             per-requester address
//     m_write_data_i       per-requester write data
//     m_rdy_o              request accepted (one-hot or zero)
//     m_valid_o            read data valid (one-hot or zero)
//     m_error_o            error response (one-hot or zero)
//     m_read_data_o        read data broadcast, qualified by m_valid_o
//     s_wr_o/s_rd_o        controller write byte enables / read request
//     s_addr_o             controller address
//     s_write_data_o       controller write data
//     s_rdy_i/s_valid_i    controller accept / read data valid
//     s_error_i            controller error
//     s_read_data_i        controller read data
module sdram_ctrl_arbiter
  import sdram_ctrl_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]   m_wr_i,
  input  logic [N_REQ-1:0]                     m_rd_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     m_write_data_i,
  output logic [N_REQ-1:0]                     m_rdy_o,
  output logic [N_REQ-1:0]                     m_valid_o,
  output logic [N_REQ-1:0]                     m_error_o,
  output logic [DATA_WIDTH-1:0]                m_read_data_o,
  output logic [DATA_WIDTH/8-1:0]              s_wr_o,
  output logic                                 s_rd_o,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic [DATA_WIDTH-1:0]                s_write_data_o,
  input  logic                                 s_rdy_i,
  input  logic                                 s_valid_i,
  input  logic                                 s_error_i,
  input  logic [DATA_WIDTH-1:0]                s_read_data_i
);

  localparam int WORD_LEN  = DATA_WIDTH / 8;
  localparam int IDX_W     = int'(req_idx_w(N_REQ));
  localparam int TIMEOUT_W = int'(cnt_w(TIMEOUT));

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 || TIMEOUT_W < 1) begin : g_bad_param
    $error("sdram_ctrl_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [N_REQ-1:0] pending;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             g_rd;
  logic             g_wr;

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pending[i] = m_rd_i[i] | (|m_wr_i[i]);
    end
  end

  sdram_ctrl_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i  (pending),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign g_rd          = m_rd_i[grant_q];
  assign g_wr          = |m_wr_i[grant_q];
  assign m_read_data_o = s_read_data_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
`ifdef SDRAM_ARB_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    m_rdy_o        = '0;
    m_valid_o      = '0;
    m_error_o      = '0;
    s_wr_o         = '0;
    s_rd_o         = 1'b0;
    s_addr_o       = '0;
    s_write_data_o = '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    wdog_d         = wdog_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        m_error_o[grant_q] = s_error_i;
        if (!(g_rd || g_wr)) begin
          // Requester withdrew before acceptance: release without
          // counting it as served.
          state_d = IDLE;
        end else begin
          s_rd_o         = g_rd;
          s_wr_o         = g_rd ? '0 : m_wr_i[grant_q];
          s_addr_o       = m_addr_i[grant_q];
          s_write_data_o = m_write_data_i[grant_q];
          m_rdy_o[grant_q] = s_rdy_i;
          if (s_rdy_i) begin
            last_d  = grant_q;
            state_d = g_rd ? WAIT_RD : IDLE;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end

      WAIT_RD: begin
`ifdef SDRAM_ARB_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
`endif
        if (s_valid_i) begin
          m_valid_o[grant_q] = 1'b1;
          m_error_o[grant_q] = s_error_i;
          state_d            = IDLE;
`ifdef SDRAM_ARB_TIMEOUT_EN
        end else if (wdog_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          m_error_o[grant_q] = 1'b1;
          state_d            = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep every handshake output quiet while reset is asserted, even
    // before the first reset edge has initialised the state register.
    if (!rst_n_i) begin
      m_rdy_o        = '0;
      m_valid_o      = '0;
      m_error_o      = '0;
      s_wr_o         = '0;
      s_rd_o         = 1'b0;
      s_addr_o       = '0;
      s_write_data_o = '0;
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_arbiter.sv
module tb_sdram_ctrl_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WL = DW / 8;
  localparam int TO = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_n_i;
  logic [N-1:0][WL-1:0]     m_wr_i;
  logic [N-1:0]             m_rd_i;
  logic [N-1:0][AW-1:0]     m_addr_i;
  logic [N-1:0][DW-1:0]     m_write_data_i;
  logic [N-1:0]             m_rdy_o;
  logic [N-1:0]             m_valid_o;
  logic [N-1:0]             m_error_o;
  logic [DW-1:0]            m_read_data_o;
  logic [WL-1:0]            s_wr_o;
  logic                     s_rd_o;
  logic [AW-1:0]            s_addr_o;
  logic [DW-1:0]            s_write_data_o;
  logic                     s_rdy_i;
  logic                     s_valid_i;
  logic                     s_error_i;
  logic [DW-1:0]            s_read_data_i;

  sdram_ctrl_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .m_wr_i         (m_wr_i),
    .m_rd_i         (m_rd_i),
    .m_addr_i       (m_addr_i),
    .m_write_data_i (m_write_data_i),
    .m_rdy_o        (m_rdy_o),
    .m_valid_o      (m_valid_o),
    .m_error_o      (m_error_o),
    .m_read_data_o  (m_read_data_o),
    .s_wr_o         (s_wr_o),
    .s_rd_o         (s_rd_o),
    .s_addr_o       (s_addr_o),
    .s_write_data_o (s_write_data_o),
    .s_rdy_i        (s_rdy_i),
    .s_valid_i      (s_valid_i),
    .s_error_i      (s_error_i),
    .s_read_data_i  (s_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   last_m   = N - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] pend_now();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_rd_i[i] | (|m_wr_i[i]);
    return p;
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {s_rd_o, s_wr_o, m_rdy_o, m_valid_o, m_error_o, s_addr_o}, 64'd0);
    chk({tag, "_wdata"}, s_write_data_o, 64'd0);
  endtask

  // Acts as the controller for one read: accept on first sight, return data
  // lat cycles after the accept cycle.
  task automatic serve_read(input logic [31:0] rdata, input int lat,
                            input logic err, input bit drop);
    bit   seen;
    int   own;
    exp_t e;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (s_rd_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rd_issue", 64'(seen), 64'd1);
    if (!seen) return;
    own = pick(pend_now(), last_m);
    chk("rd_s_wr_zero", s_wr_o, 64'd0);
    chk("rd_s_addr", s_addr_o, m_addr_i[own]);
    s_rdy_i = 1'b1;
    #1;
    chk("rd_m_rdy", m_rdy_o, 64'd1 << own);
    e.owner = own;
    e.data  = rdata;
    e.err   = err;
    exp_q.push_back(e);
    last_m = own;
    tick();
    s_rdy_i = 1'b0;
    if (drop) begin
      m_rd_i[own] = 1'b0;
      m_wr_i[own] = '0;
    end
    #1;
    chk("wait_quiet", {s_rd_o, s_wr_o, m_rdy_o, m_valid_o}, 64'd0);
    for (int n = 1; n < lat; n++) tick();
    s_valid_i     = 1'b1;
    s_read_data_i = rdata;
    s_error_i     = err;
    #1;
    chk("sb_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rd_m_valid", m_valid_o, 64'd1 << e.owner);
      chk("rd_data", m_read_data_o, e.data);
      chk("rd_m_error", m_error_o, e.err ? (64'd1 << e.owner) : 64'd0);
    end
    tick();
    s_valid_i     = 1'b0;
    s_error_i     = 1'b0;
    s_read_data_i = '0;
  endtask

  initial begin
    rst_n_i        = 1'b0;
    m_rd_i         = 2'b11;
    m_wr_i         = '0;
    m_addr_i[0]    = 32'h0000_0010;
    m_addr_i[1]    = 32'h0000_0020;
    m_write_data_i = '0;
    s_rdy_i        = 1'b0;
    s_valid_i      = 1'b0;
    s_error_i      = 1'b0;
    s_read_data_i  = '0;

    // Reset held 3 cycles with both requesting, then requester 0 first.
    #1;
    chk_quiet("rst_pre_edge");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("rst_hold");
    end
    rst_n_i = 1'b1;
    serve_read(32'hA5A5_0000, 3, 1'b0, 1'b1);
    serve_read(32'hA5A5_0001, 3, 1'b0, 1'b1);

    // Single write from requester 1, accepted on its second ISSUE cycle.
    m_wr_i[1]         = 4'hF;
    m_addr_i[1]       = 32'h0000_0100;
    m_write_data_i[1] = 32'hDEAD_BEEF;
    tick();
    chk("wr_s_wr", s_wr_o, 64'hF);
    chk("wr_s_rd", 64'(s_rd_o), 64'd0);
    chk("wr_s_addr", s_addr_o, 64'h100);
    chk("wr_s_wdata", s_write_data_o, 64'hDEAD_BEEF);
    chk("wr_rdy_wait", m_rdy_o, 64'd0);
    tick();
    s_rdy_i = 1'b1;
    #1;
    chk("wr_m_rdy", m_rdy_o, 64'b10);
    last_m = 1;
    tick();
    s_rdy_i   = 1'b0;
    m_wr_i[1] = '0;
    #1;
    chk_quiet("wr_done_idle");
    tick();
    chk_quiet("wr_stay_idle");

    // Contention: both read continuously, strict rotation 0,1,0,1.
    m_addr_i[1] = 32'h0000_0020;
    m_rd_i      = 2'b11;
    for (int t = 0; t < 4; t++) begin
      serve_read(32'h1000_0000 + 32'(t), 3, 1'b0, 1'b0);
    end
    m_rd_i = 2'b00;

    // Read and write together on requester 0: read wins.
    m_rd_i[0]         = 1'b1;
    m_wr_i[0]         = 4'hF;
    m_write_data_i[0] = 32'h1234_5678;
    serve_read(32'h4444_4444, 5, 1'b0, 1'b1);

    // Error with read data on requester 1.
    m_rd_i[1] = 1'b1;
    serve_read(32'h5555_5555, 2, 1'b1, 1'b1);

    // Read that never returns.
    m_addr_i[0] = 32'h0000_0600;
    m_rd_i      = 2'b01;
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 10; n++) begin
        tick();
        if (s_rd_o) begin
          seen = 1'b1;
          break;
        end
      end
      chk("to_issue", 64'(seen), 64'd1);
    end
    s_rdy_i = 1'b1;
    #1;
    chk("to_m_rdy", m_rdy_o, 64'b01);
    tick();
    s_rdy_i = 1'b0;
    m_rd_i  = 2'b10;
    #1;
`ifdef SDRAM_ARB_TIMEOUT_EN
    begin
      int hit;
      logic [N-1:0] err_seen;
      hit      = 0;
      err_seen = '0;
      for (int k = 1; k <= 40; k++) begin
        if (k > 1) tick();
        if (m_error_o != '0) begin
          hit      = k;
          err_seen = m_error_o;
          break;
        end
      end
      chk("to_cycle", 64'(hit), 64'd16);
      chk("to_err_owner", err_seen, 64'b01);
      tick();
      s_valid_i = 1'b1;
      #1;
      chk("to_late_valid", m_valid_o, 64'd0);
      tick();
      s_valid_i = 1'b0;
      #1;
      chk("to_next_grant_rd", 64'(s_rd_o), 64'd1);
      chk("to_next_grant_addr", s_addr_o, 64'h20);
    end
`else
    begin
      logic activity;
      activity = 1'b0;
      for (int k = 0; k < 30; k++) begin
        tick();
        activity = activity | s_rd_o | (|m_error_o) | (|m_valid_o) | (|m_rdy_o);
      end
      chk("no_to_stuck", 64'(activity), 64'd0);
    end
`endif

    // Reset abandons the transaction; a stray s_valid afterwards is ignored.
    rst_n_i = 1'b0;
    m_rd_i  = 2'b00;
    tick();
    chk_quiet("rst_mid");
    rst_n_i = 1'b1;
    tick();
    s_valid_i     = 1'b1;
    s_error_i     = 1'b1;
    s_read_data_i = 32'hCAFE_F00D;
    #1;
    chk("stray_valid", {m_valid_o, m_error_o}, 64'd0);
    chk("rdata_bcast", m_read_data_o, 64'hCAFE_F00D);
    tick();
    s_valid_i     = 1'b0;
    s_error_i     = 1'b0;
    s_read_data_i = '0;
    #1;
    chk_quiet("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

endmodule
